// File: rtl/fruit_pkg.sv
// Shared types and helpers for the fruit spawn scheduler.
package fruit_pkg;

    localparam int NUM_FRUITS = 6;

    typedef enum logic [1:0] {
        FRUIT_BANANA = 2'd0,
        FRUIT_APPLE  = 2'd1,
        FRUIT_GRAPE  = 2'd2
    } fruit_t;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOAD_DELAY = 3'd1,
        S_WAIT       = 3'd2,
        S_SEARCH     = 3'd3,
        S_SPAWN      = 3'd4
    } state_t;

    function automatic logic [1:0] mod3_8b(input logic [7:0] r);
        logic [7:0] m;
        m = r % 8'd3;
        return m[1:0];
    endfunction

endpackage

// File: rtl/fruit_spawn_scheduler_finder.sv
// Finds the first free slot scanning upward from rr_ptr, wrapping 5->0.
module rr_free_slot_finder
    import fruit_pkg::*;
(
    input  logic [5:0] free,
    input  logic [2:0] rr_ptr,
    output logic       found,
    output logic [2:0] idx
);

    logic [3:0] pos;

    always_comb begin
        found = 1'b0;
        idx   = 3'd0;
        pos   = 4'd0;
        for (int k = 0; k < NUM_FRUITS; k++) begin
            pos = {1'b0, rr_ptr} + 4'(k);
            if (pos >= 4'(NUM_FRUITS))
                pos = pos - 4'(NUM_FRUITS);
            if (!found && free[pos[2:0]]) begin
                found = 1'b1;
                idx   = pos[2:0];
            end
        end
    end

endmodule

// File: rtl/fruit_spawn_scheduler.sv
// Frame-paced fruit spawner: random delay, round-robin slot pick,
// random type, and active-slot tracking until collected.
module fruit_spawn_scheduler
    import fruit_pkg::*;
#(
    parameter int         MIN_DELAY  = 30,
    parameter logic [7:0] DELAY_MASK = 8'h3F,
    parameter int         MAX_ACTIVE = 4
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        game_enable,
    input  logic [7:0]  rand_in,
    input  logic [5:0]  collect,
    output logic [5:0]  fruit_active,
    output logic [11:0] fruit_types,
    output logic        spawn_valid,
    output logic [2:0]  spawn_idx,
    output logic [1:0]  spawn_type
);

    state_t     state;
    logic [8:0] delay_cnt;
    logic [2:0] rr_ptr;
    logic [2:0] idx_q;
    logic       found;
    logic [2:0] find_idx;
    logic [2:0] active_cnt;
    logic       at_limit;
    logic [1:0] rand_type;
    logic [2:0] next_ptr;
    logic [5:0] spawn_mask;

    rr_free_slot_finder u_finder (
        .free   (~fruit_active),
        .rr_ptr (rr_ptr),
        .found  (found),
        .idx    (find_idx)
    );

    always_comb begin
        active_cnt = 3'd0;
        for (int i = 0; i < NUM_FRUITS; i++)
            active_cnt = active_cnt + 3'(fruit_active[i]);
    end

    assign at_limit   = active_cnt >= 3'(MAX_ACTIVE);
    assign rand_type  = mod3_8b(rand_in);
    assign next_ptr   = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    assign spawn_mask = (state == S_SPAWN) ? (6'b000001 << idx_q) : 6'b0;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= S_IDLE;
            delay_cnt    <= 9'd0;
            rr_ptr       <= 3'd0;
            idx_q        <= 3'd0;
            fruit_active <= 6'b0;
            fruit_types  <= 12'b0;
            spawn_valid  <= 1'b0;
            spawn_idx    <= 3'd0;
            spawn_type   <= 2'd0;
        end else if (!game_enable) begin
            // mid-level abort wipes the board
            state        <= S_IDLE;
            delay_cnt    <= 9'd0;
            rr_ptr       <= 3'd0;
            fruit_active <= 6'b0;
            fruit_types  <= 12'b0;
            spawn_valid  <= 1'b0;
        end else begin
            spawn_valid  <= 1'b0;
            fruit_active <= (fruit_active & ~collect) | spawn_mask;
            case (state)
                S_IDLE: state <= S_LOAD_DELAY;
                S_LOAD_DELAY: begin
                    delay_cnt <= 9'(MIN_DELAY)
                               + {1'b0, rand_in & DELAY_MASK};
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (startOfFrame) begin
                        if (delay_cnt == 9'd0)
                            state <= S_SEARCH;
                        else
                            delay_cnt <= delay_cnt - 9'd1;
                    end
                end
                S_SEARCH: begin
                    if (found && !at_limit) begin
                        idx_q <= find_idx;
                        state <= S_SPAWN;
                    end
                end
                S_SPAWN: begin
                    spawn_valid <= 1'b1;
                    spawn_idx   <= idx_q;
                    spawn_type  <= rand_type;
                    fruit_types[{idx_q, 1'b0} +: 2] <= rand_type;
                    rr_ptr      <= next_ptr;
                    state       <= S_LOAD_DELAY;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
